decim_sched: RTL and testbench

DECIM_SCHED -- requirements
Module: decim_sched

---
 rtl/decim_sched.sv | 185 ++++++++++++++++++
 tb/tb_decim_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decim_sched.sv
// rtl/decim_sched.sv - decimating sample scheduler with phase alignment and ensemble framing
//
// Keeps one of every R valid input samples after discarding an initial
// alignment phase. It frames a fixed-length ensemble of outputs behind a
// single-entry output register that uses a valid/ready handshake.
//
// Ports:
//   fast_clk                 clock, all logic on the rising edge
//   reset_n                  synchronous active-low reset
//   cfg_ratio/phase/len      ensemble configuration, latched on an accepted start
//   start, abort             ensemble control
//   din_valid_Ff/re/im       input sample stream (no backpressure)
//   dout_valid/ready/re/im   output sample stream
//   dout_last                final output of the ensemble
//   busy, done, overflow     status

module decim_sched (
    input  logic        fast_clk,
    input  logic        reset_n,
    input  logic [3:0]  cfg_ratio,
    input  logic [3:0]  cfg_phase,
    input  logic [7:0]  cfg_len,
    input  logic        start,
    input  logic        abort,
    input  logic        din_valid_Ff,
    input  logic [31:0] din_re_Ff,
    input  logic [31:0] din_im_Ff,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [31:0] dout_re,
    output logic [31:0] dout_im,
    output logic        dout_last,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, ALIGN, RUN, DRAIN} state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  ratio_q;
    logic [3:0]  phase_q;
    logic [8:0]  len_q;
    logic [3:0]  align_cnt;
    logic [3:0]  ph_cnt;
    logic [8:0]  out_cnt;

    logic        accept;
    logic        handshake;
    logic        keep;
    logic        load;
    logic        drop;
    logic        load_last;
    logic        finish;
    logic        kill;
    logic [3:0]  phase_clamped;

    assign busy = (state != IDLE);

    always_ff @(posedge fast_clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        accept        = 1'b0;
        load          = 1'b0;
        drop          = 1'b0;
        load_last     = 1'b0;
        finish        = 1'b0;
        handshake     = dout_valid && dout_ready;
        keep          = din_valid_Ff && (ph_cnt == 4'd0);
        kill          = abort && (state != IDLE);
        phase_clamped = (cfg_phase > cfg_ratio) ? cfg_ratio : cfg_phase;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept   = 1'b1;
                    state_nx = (phase_clamped != 4'd0) ? ALIGN : RUN;
                end
            end
            ALIGN: begin
                if (din_valid_Ff && (align_cnt + 4'd1 == phase_q)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (keep) begin
                    // The output register is only blocked when it is full and
                    // not draining this cycle; a same-cycle handshake frees it.
                    if (dout_valid && !dout_ready) begin
                        drop = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (out_cnt + 9'd1 == len_q) begin
                            load_last = 1'b1;
                            state_nx  = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (handshake) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Abort overrides everything, including a handshake in DRAIN.
        if (kill) begin
            state_nx  = IDLE;
            load      = 1'b0;
            drop      = 1'b0;
            load_last = 1'b0;
            finish    = 1'b0;
        end
    end

    always_ff @(posedge fast_clk) begin
        if (!reset_n) begin
            ratio_q    <= 4'd0;
            phase_q    <= 4'd0;
            len_q      <= 9'd0;
            align_cnt  <= 4'd0;
            ph_cnt     <= 4'd0;
            out_cnt    <= 9'd0;
            dout_valid <= 1'b0;
            dout_re    <= 32'd0;
            dout_im    <= 32'd0;
            dout_last  <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= finish;

            if (accept) begin
                ratio_q   <= cfg_ratio;
                phase_q   <= phase_clamped;
                len_q     <= (cfg_len == 8'd0) ? 9'd256 : {1'b0, cfg_len};
                overflow  <= 1'b0;
                align_cnt <= 4'd0;
                ph_cnt    <= 4'd0;
                out_cnt   <= 9'd0;
            end

            if (state == ALIGN && din_valid_Ff) begin
                align_cnt <= align_cnt + 4'd1;
            end

            if (state == RUN && din_valid_Ff) begin
                ph_cnt <= (ph_cnt == ratio_q) ? 4'd0 : ph_cnt + 4'd1;
            end

            if (drop) begin
                overflow <= 1'b1;
            end

            if (handshake) begin
                dout_valid <= 1'b0;
            end

            if (load) begin
                dout_valid <= 1'b1;
                dout_re    <= din_re_Ff;
                dout_im    <= din_im_Ff;
                dout_last  <= load_last;
                out_cnt    <= out_cnt + 9'd1;
            end

            if (finish || kill) begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decim_sched.sv
// tb/tb_decim_sched.sv - randomized and directed bench for decim_sched

module tb_decim_sched;

    logic        fast_clk = 1'b0;
    logic        reset_n;
    logic [3:0]  cfg_ratio;
    logic [3:0]  cfg_phase;
    logic [7:0]  cfg_len;
    logic        start;
    logic        abort;
    logic        din_valid_Ff;
    logic [31:0] din_re_Ff;
    logic [31:0] din_im_Ff;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_re;
    logic [31:0] dout_im;
    logic        dout_last;
    logic        busy;
    logic        done;
    logic        overflow;

    always #5 fast_clk = ~fast_clk;

    decim_sched dut (
        .fast_clk     (fast_clk),
        .reset_n      (reset_n),
        .cfg_ratio    (cfg_ratio),
        .cfg_phase    (cfg_phase),
        .cfg_len      (cfg_len),
        .start        (start),
        .abort        (abort),
        .din_valid_Ff (din_valid_Ff),
        .din_re_Ff    (din_re_Ff),
        .din_im_Ff    (din_im_Ff),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_re      (dout_re),
        .dout_im      (dout_im),
        .dout_last    (dout_last),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    int vectors;
    int miscompares;

    // Reference model: the ensemble is described by the index of each valid
    // sample since start; index k is kept when k >= P and (k - P) is a
    // multiple of R. A single output slot models the handshake register.
    bit          m_busy, m_valid, m_last, m_done, m_ovf;
    int          m_r, m_p, m_len, m_seen, m_loaded;
    logic [31:0] m_re, m_im;

    logic [31:0] obs_q[$];
    int          done_cnt;

    task automatic step();
        bit hs;
        bit nd;
        int k;
        hs = m_valid && (dout_ready === 1'b1);
        nd = 1'b0;
        if (dout_valid === 1'b1 && dout_ready === 1'b1) obs_q.push_back(dout_re);
        if (reset_n !== 1'b1) begin
            m_busy = 0; m_valid = 0; m_last = 0; m_ovf = 0; m_re = '0; m_im = '0;
        end else if (!m_busy) begin
            if (start && !abort) begin
                m_r      = int'(cfg_ratio) + 1;
                m_p      = (cfg_phase > cfg_ratio) ? int'(cfg_ratio) : int'(cfg_phase);
                m_len    = (cfg_len == 8'd0) ? 256 : int'(cfg_len);
                m_busy   = 1; m_seen = 0; m_loaded = 0; m_ovf = 0;
            end
        end else if (abort) begin
            m_busy = 0; m_valid = 0; m_last = 0;
        end else if (m_loaded == m_len) begin
            if (hs) begin
                m_valid = 0; m_last = 0; m_busy = 0; nd = 1;
            end
        end else begin
            if (hs) m_valid = 0;
            if (din_valid_Ff) begin
                k = m_seen;
                m_seen++;
                if (k >= m_p && (k - m_p) % m_r == 0) begin
                    if (m_valid) begin
                        m_ovf = 1;
                    end else begin
                        m_valid = 1; m_re = din_re_Ff; m_im = din_im_Ff;
                        m_loaded++;
                        m_last = (m_loaded == m_len);
                    end
                end
            end
        end
        m_done = nd;
        @(posedge fast_clk);
        #1;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic do_start(input logic [3:0] r, input logic [3:0] p, input logic [7:0] l);
        cfg_ratio = r; cfg_phase = p; cfg_len = l;
        start = 1'b1; din_valid_Ff = 1'b0;
        step();
        start = 1'b0;
        obs_q.delete();
        done_cnt = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        vectors++;
        if ({dout_valid, dout_last, busy, done, overflow, dout_re, dout_im} !== 69'd0) begin
            miscompares++;
            $display("FAIL reset_state: got v%b l%b b%b d%b o%b re=%h im=%h, want all zero",
                     dout_valid, dout_last, busy, done, overflow, dout_re, dout_im);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int hs_t, done_t;
        hs_t = -1; done_t = -1;
        do_start(4'd3, 4'd0, 8'd3);
        for (int t = 0; t < 20; t++) begin
            din_valid_Ff = 1'b1; din_re_Ff = t; din_im_Ff = ~t; dout_ready = 1'b1;
            if (dout_valid === 1'b1 && dout_re === 32'd8) hs_t = t;
            step();
            if (done === 1'b1) done_t = t;
            vectors++;
            if ({dout_valid, dout_last, busy, done, overflow} !== {m_valid, m_last, m_busy, m_done, m_ovf} ||
                (m_valid && {dout_re, dout_im} !== {m_re, m_im})) begin
                miscompares++;
                $display("FAIL basic_cycle t=%0d: got vlbdo=%b%b%b%b%b re=%h, want %b%b%b%b%b re=%h", t,
                         dout_valid, dout_last, busy, done, overflow, dout_re, m_valid, m_last, m_busy, m_done, m_ovf, m_re);
            end
        end
        vectors++;
        if (obs_q.size() != 3 || obs_q[0] !== 32'd0 || obs_q[1] !== 32'd4 || obs_q[2] !== 32'd8) begin
            miscompares++;
            $display("FAIL basic_outputs: got %0d outputs %p, want 0,4,8", obs_q.size(), obs_q);
        end
        vectors++;
        if (done_cnt != 1 || done_t != hs_t || hs_t < 0) begin
            miscompares++;
            $display("FAIL basic_done: got %0d pulses at t=%0d, want 1 pulse at t=%0d", done_cnt, done_t, hs_t);
        end
    endtask

    task automatic test_phase();
        int fall_t, done_t;
        bit prev_busy;
        fall_t = -1; done_t = -1; prev_busy = 1'b1;
        do_start(4'd2, 4'd2, 8'd2);
        for (int t = 0; t < 16; t++) begin
            din_valid_Ff = 1'b1; din_re_Ff = t; din_im_Ff = t * 3; dout_ready = 1'b1;
            step();
            if (prev_busy && busy === 1'b0 && fall_t < 0) fall_t = t;
            if (done === 1'b1) done_t = t;
            prev_busy = (busy === 1'b1);
            vectors++;
            if ({dout_valid, dout_last, busy, done, overflow} !== {m_valid, m_last, m_busy, m_done, m_ovf} ||
                (m_valid && {dout_re, dout_im} !== {m_re, m_im})) begin
                miscompares++;
                $display("FAIL phase_cycle t=%0d: got vlbdo=%b%b%b%b%b re=%h, want %b%b%b%b%b re=%h", t,
                         dout_valid, dout_last, busy, done, overflow, dout_re, m_valid, m_last, m_busy, m_done, m_ovf, m_re);
            end
        end
        vectors++;
        if (obs_q.size() != 2 || obs_q[0] !== 32'd2 || obs_q[1] !== 32'd5) begin
            miscompares++;
            $display("FAIL phase_outputs: got %0d outputs %p, want 2,5", obs_q.size(), obs_q);
        end
        vectors++;
        if (fall_t < 0 || fall_t != done_t) begin
            miscompares++;
            $display("FAIL phase_busy_done: busy fell at t=%0d, done at t=%0d, want same cycle", fall_t, done_t);
        end
    endtask

    task automatic test_overflow();
        do_start(4'd1, 4'd0, 8'd3);
        for (int t = 0; t < 16; t++) begin
            din_valid_Ff = 1'b1; din_re_Ff = t; din_im_Ff = 32'hA000_0000 + t; dout_ready = (t >= 6);
            step();
            vectors++;
            if ({dout_valid, dout_last, busy, done, overflow} !== {m_valid, m_last, m_busy, m_done, m_ovf} ||
                (m_valid && {dout_re, dout_im} !== {m_re, m_im})) begin
                miscompares++;
                $display("FAIL ovf_cycle t=%0d: got vlbdo=%b%b%b%b%b re=%h, want %b%b%b%b%b re=%h", t,
                         dout_valid, dout_last, busy, done, overflow, dout_re, m_valid, m_last, m_busy, m_done, m_ovf, m_re);
            end
        end
        vectors++;
        if (overflow !== 1'b1 || obs_q.size() != 3 || obs_q[0] !== 32'd0 || obs_q[1] !== 32'd6 || obs_q[2] !== 32'd8) begin
            miscompares++;
            $display("FAIL ovf_result: got overflow=%b outputs %p, want overflow=1 outputs 0,6,8", overflow, obs_q);
        end
    endtask

    task automatic test_abort();
        for (int t = 0; t < 6; t++) begin
            if (t == 0) do_start(4'd1, 4'd0, 8'd5);
            din_valid_Ff = 1'b1; din_re_Ff = t; din_im_Ff = t; dout_ready = (t >= 3); abort = (t == 4);
            step();
            vectors++;
            if ({dout_valid, dout_last, busy, done, overflow} !== {m_valid, m_last, m_busy, m_done, m_ovf}) begin
                miscompares++;
                $display("FAIL abort_cycle t=%0d: got vlbdo=%b%b%b%b%b, want %b%b%b%b%b", t,
                         dout_valid, dout_last, busy, done, overflow, m_valid, m_last, m_busy, m_done, m_ovf);
            end
            if (t == 4) begin
                vectors++;
                if (busy !== 1'b0 || dout_valid !== 1'b0 || done !== 1'b0 || obs_q.size() != 1) begin
                    miscompares++;
                    $display("FAIL abort_idle: got busy=%b valid=%b done=%b outputs=%0d, want 0 0 0 1",
                             busy, dout_valid, done, obs_q.size());
                end
            end
        end
        abort = 1'b0;
        vectors++;
        if (done_cnt != 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", done_cnt);
        end
        do_start(4'd0, 4'd0, 8'd2);
        for (int t = 0; t < 6; t++) begin
            din_valid_Ff = 1'b1; din_re_Ff = 100 + t; din_im_Ff = t; dout_ready = 1'b1;
            step();
            vectors++;
            if ({dout_valid, dout_last, busy, done, overflow} !== {m_valid, m_last, m_busy, m_done, m_ovf} ||
                (m_valid && {dout_re, dout_im} !== {m_re, m_im})) begin
                miscompares++;
                $display("FAIL abort_restart t=%0d: got vlbdo=%b%b%b%b%b, want %b%b%b%b%b", t,
                         dout_valid, dout_last, busy, done, overflow, m_valid, m_last, m_busy, m_done, m_ovf);
            end
        end
        vectors++;
        if (overflow !== 1'b0 || done_cnt != 1 || obs_q.size() != 2) begin
            miscompares++;
            $display("FAIL abort_restart_result: got overflow=%b done=%0d outputs=%0d, want 0 1 2",
                     overflow, done_cnt, obs_q.size());
        end
    endtask

    task automatic test_len256();
        logic [31:0] last_seen;
        bit          seq_ok;
        last_seen = '1;
        do_start(4'd0, 4'd0, 8'd0);
        for (int t = 0; t < 262; t++) begin
            din_valid_Ff = 1'b1; din_re_Ff = t; din_im_Ff = ~t; dout_ready = 1'b1;
            step();
            if (dout_valid === 1'b1 && dout_last === 1'b1) last_seen = dout_re;
            vectors++;
            if ({dout_valid, dout_last, busy, done, overflow} !== {m_valid, m_last, m_busy, m_done, m_ovf} ||
                (m_valid && {dout_re, dout_im} !== {m_re, m_im})) begin
                miscompares++;
                $display("FAIL len256_cycle t=%0d: got vlbdo=%b%b%b%b%b re=%h, want %b%b%b%b%b re=%h", t,
                         dout_valid, dout_last, busy, done, overflow, dout_re, m_valid, m_last, m_busy, m_done, m_ovf, m_re);
            end
        end
        seq_ok = (obs_q.size() == 256);
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== i) seq_ok = 0;
        vectors++;
        if (!seq_ok || last_seen !== 32'd255 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL len256_result: got %0d outputs last=%0d done=%0d, want 256 consecutive last=255 done=1",
                     obs_q.size(), last_seen, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_start(4'd1, 4'd0, 8'd10);
        for (int t = 0; t < 3; t++) begin
            din_valid_Ff = 1'b1; din_re_Ff = t; din_im_Ff = t; dout_ready = 1'b0;
            step();
        end
        vectors++;
        if (dout_valid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre: got valid=%b busy=%b, want 1 1", dout_valid, busy);
        end
        reset_n = 1'b0;
        step();
        vectors++;
        if ({dout_valid, dout_last, busy, done, overflow, dout_re, dout_im} !== 69'd0) begin
            miscompares++;
            $display("FAIL rstmid_zero: got v%b l%b b%b d%b o%b re=%h im=%h, want all zero",
                     dout_valid, dout_last, busy, done, overflow, dout_re, dout_im);
        end
        reset_n = 1'b1;
        do_start(4'd2, 4'd1, 8'd2);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_start: got busy=%b, want 1", busy);
        end
        for (int t = 0; t < 14; t++) begin
            din_valid_Ff = 1'b1; din_re_Ff = 50 + t; din_im_Ff = t; dout_ready = 1'b1;
            step();
            vectors++;
            if ({dout_valid, dout_last, busy, done, overflow} !== {m_valid, m_last, m_busy, m_done, m_ovf} ||
                (m_valid && {dout_re, dout_im} !== {m_re, m_im})) begin
                miscompares++;
                $display("FAIL rstmid_cycle t=%0d: got vlbdo=%b%b%b%b%b re=%h, want %b%b%b%b%b re=%h", t,
                         dout_valid, dout_last, busy, done, overflow, dout_re, m_valid, m_last, m_busy, m_done, m_ovf, m_re);
            end
        end
        vectors++;
        if (obs_q.size() != 2 || obs_q[0] !== 32'd51 || obs_q[1] !== 32'd54 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL rstmid_result: got outputs %p done=%0d, want 51,54 done=1", obs_q, done_cnt);
        end
    endtask

    task automatic test_random();
        for (int e = 0; e < 8; e++) begin
            do_start(4'($urandom), 4'($urandom), 8'($urandom_range(1, 12)));
            for (int t = 0; t < 600 && m_busy; t++) begin
                din_valid_Ff = ($urandom_range(0, 9) < 7);
                din_re_Ff    = $urandom;
                din_im_Ff    = $urandom;
                dout_ready   = ($urandom_range(0, 9) < 7);
                cfg_ratio    = 4'($urandom);
                cfg_phase    = 4'($urandom);
                cfg_len      = 8'($urandom);
                start        = ($urandom_range(0, 7) == 0);
                abort        = (e == 5) && ($urandom_range(0, 29) == 0);
                step();
                vectors++;
                if ({dout_valid, dout_last, busy, done, overflow} !== {m_valid, m_last, m_busy, m_done, m_ovf} ||
                    (m_valid && {dout_re, dout_im} !== {m_re, m_im})) begin
                    miscompares++;
                    $display("FAIL random e=%0d t=%0d: got vlbdo=%b%b%b%b%b re=%h, want %b%b%b%b%b re=%h", e, t,
                             dout_valid, dout_last, busy, done, overflow, dout_re, m_valid, m_last, m_busy, m_done, m_ovf, m_re);
                end
            end
            start = 1'b0; abort = 1'b0;
            step();
            vectors++;
            if ({busy, dout_valid, done} !== 3'b000) begin
                miscompares++;
                $display("FAIL random_end e=%0d: got busy=%b valid=%b done=%b, want 0 0 0", e, busy, dout_valid, done);
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; done_cnt = 0;
        m_busy = 0; m_valid = 0; m_last = 0; m_done = 0; m_ovf = 0;
        m_r = 1; m_p = 0; m_len = 1; m_seen = 0; m_loaded = 0; m_re = '0; m_im = '0;
        reset_n = 1'b0; cfg_ratio = '0; cfg_phase = '0; cfg_len = '0;
        start = 1'b0; abort = 1'b0; din_valid_Ff = 1'b0; din_re_Ff = '0; din_im_Ff = '0;
        dout_ready = 1'b0;
        test_reset();
        test_basic();
        test_phase();
        test_overflow();
        test_abort();
        test_len256();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
